// File: rtl/bus_trace_if.sv
// Bus trace buffer interface: capture controls, sampled processor signals and
// the valid/ready drain port. clk/rst stay outside as plain ports.
interface bus_trace_if #(
    parameter int DEPTH = 16,
    parameter int BUS_W = 16,
    parameter int CMD_W = 23,
    parameter int TS_W  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             arm;
    logic             stop;
    logic [BUS_W-1:0] bus;
    logic [CMD_W-1:0] command;
    logic             rd_ready;
    logic             rd_valid;
    logic [CMD_W-1:0] rd_cmd;
    logic [BUS_W-1:0] rd_bus;
    logic [TS_W-1:0]  rd_ts;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             capturing;
    logic             done;

    // Driver side: the consumer / stimulus owner.
    modport master (
        output arm, stop, bus, command, rd_ready,
        input  rd_valid, rd_cmd, rd_bus, rd_ts, count, overflow, capturing, done
    );

    // Trace buffer side.
    modport slave (
        input  arm, stop, bus, command, rd_ready,
        output rd_valid, rd_cmd, rd_bus, rd_ts, count, overflow, capturing, done
    );
endinterface

// File: rtl/bus_trace_buffer.sv
// Passive bus trace buffer: stores {ts, command, bus} whenever the processor
// command changes while capture is running, and drains the entries through a
// first-word-fall-through valid/ready port.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | not capturing; FIFO contents kept and still drainable
// ST_ARMED   | timestamp running; waiting for the first non-zero command
// ST_CAPTURE | pushing an entry on every command change
// ST_DONE    | capture ended (stop or full); contents held until re-arm
module bus_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int BUS_W        = 16,
    parameter int CMD_W        = 23,
    parameter int TS_W         = 16,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input logic        clk,
    input logic        rst,
    bus_trace_if.slave tif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = TS_W + CMD_W + BUS_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [TS_W-1:0]  ts;
    logic [CMD_W-1:0] prev_cmd;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             running;
    logic             full;
    logic             push, pop, wr_ok, flush, ts_clr;

    assign running = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = (count != '0) && tif.rd_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign wr_ok   = push && (!full || pop);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and capture strobes; stop is only seen in CAPTURE, arm only in IDLE/DONE.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        flush     = 1'b0;
        ts_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tif.arm) begin
                    state_nxt = ST_ARMED;
                    ts_clr    = 1'b1;
                end
            end
            ST_ARMED: begin
                if (tif.command != '0) begin
                    push      = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (tif.command != prev_cmd) push = 1'b1;
                if (tif.stop) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (tif.arm) begin
                    state_nxt = ST_ARMED;
                    flush     = 1'b1;
                    ts_clr    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Filling the FIFO ends the capture on the same edge as the filling push.
        if (STOP_ON_FULL && push && !pop && (count == CNT_W'(DEPTH - 1)))
            state_nxt = ST_DONE;
    end

    // Free-running timestamp while capture is active; wraps silently.
    always_ff @(posedge clk) begin
        if (rst)          ts <= '0;
        else if (ts_clr)  ts <= '0;
        else if (running) ts <= ts + 1'b1;
    end

    // Last sampled command, the reference for change detection.
    always_ff @(posedge clk) begin
        if (rst)          prev_cmd <= '0;
        else if (running) prev_cmd <= tif.command;
    end

    // FIFO storage; entry fields all come from the same edge.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= {ts, tif.command, tif.bus};
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry is forced to zero when empty so the port is clean after reset.
    assign head          = (count != '0) ? mem[rd_ptr] : '0;
    assign tif.rd_valid  = (count != '0);
    assign tif.rd_ts     = head[ENT_W-1 -: TS_W];
    assign tif.rd_cmd    = head[BUS_W +: CMD_W];
    assign tif.rd_bus    = head[BUS_W-1:0];
    assign tif.count     = count;
    assign tif.overflow  = overflow;
    assign tif.capturing = running;
    assign tif.done      = (state == ST_DONE);
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Bench for bus_trace_buffer: two DEPTH=4 instances share stimulus, one that
// keeps running and drops when full, one that stops when full.
module tb_bus_trace_buffer;
    typedef struct packed {
        logic [15:0] ts;
        logic [22:0] cmd;
        logic [15:0] bus;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_trace_if #(.DEPTH(4)) tif_a ();
    bus_trace_if #(.DEPTH(4)) tif_b ();

    assign tif_b.arm      = tif_a.arm;
    assign tif_b.stop     = tif_a.stop;
    assign tif_b.bus      = tif_a.bus;
    assign tif_b.command  = tif_a.command;
    assign tif_b.rd_ready = tif_a.rd_ready;

    bus_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1'b0)) dut_a (.clk(clk), .rst(rst), .tif(tif_a));
    bus_trace_buffer #(.DEPTH(4), .STOP_ON_FULL(1'b1)) dut_b (.clk(clk), .rst(rst), .tif(tif_b));

    int          n_cmp = 0;
    int          n_err = 0;
    entry_t      exp_q[$];
    logic [15:0] ts_m = '0;
    bit          armed_m = 1'b0;

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (armed_m) ts_m++;
    endtask

    // Present one sample; expected entries carry the pre-edge timestamp.
    task automatic drive(input logic [22:0] cmd, input logic [15:0] bv, input bit exp_push);
        tif_a.command = cmd;
        tif_a.bus     = bv;
        if (exp_push) exp_q.push_back(entry_t'({ts_m, cmd, bv}));
        tick();
    endtask

    task automatic arm_pulse();
        tif_a.arm = 1'b1;
        tick();
        tif_a.arm = 1'b0;
        armed_m   = 1'b1;
        ts_m      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tif_a.arm = 1'b0; tif_a.stop = 1'b0; tif_a.rd_ready = 1'b0;
        tif_a.command = '0; tif_a.bus = '0;
        tick();
        tick();
        rst = 1'b0;
        armed_m = 1'b0;
        exp_q.delete();
    endtask

    // Pops n entries from dut_a and scores each against the queue head.
    task automatic drain_and_score(input int n, input string name);
        entry_t e;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s[%0d]: scoreboard empty, got valid=%0b ts=%h cmd=%h bus=%h",
                         name, i, tif_a.rd_valid, tif_a.rd_ts, tif_a.rd_cmd, tif_a.rd_bus);
            end else begin
                e = exp_q.pop_front();
                if (tif_a.rd_valid !== 1'b1 || tif_a.rd_ts !== e.ts ||
                    tif_a.rd_cmd !== e.cmd || tif_a.rd_bus !== e.bus) begin
                    n_err++;
                    $display("FAIL %s[%0d]: got valid=%0b ts=%h cmd=%h bus=%h, need valid=1 ts=%h cmd=%h bus=%h",
                             name, i, tif_a.rd_valid, tif_a.rd_ts, tif_a.rd_cmd, tif_a.rd_bus,
                             e.ts, e.cmd, e.bus);
                end
            end
            tif_a.rd_ready = 1'b1;
            tick();
            tif_a.rd_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (tif_a.count !== 3'd0 || tif_a.rd_valid !== 1'b0 || tif_a.capturing !== 1'b0 ||
            tif_a.done !== 1'b0 || tif_a.overflow !== 1'b0 || tif_a.rd_cmd !== '0) begin
            n_err++;
            $display("FAIL reset_initial: count=%0d valid=%0b cap=%0b done=%0b ovf=%0b cmd=%h, need all 0",
                     tif_a.count, tif_a.rd_valid, tif_a.capturing, tif_a.done, tif_a.overflow, tif_a.rd_cmd);
        end
        arm_pulse();
        drive(23'h1, 16'h1, 1'b1);
        drive(23'h2, 16'h2, 1'b1);
        drive(23'h3, 16'h3, 1'b1);
        n_cmp++;
        if (tif_a.count !== 3'd3) begin
            n_err++;
            $display("FAIL reset_precount: count=%0d need 3", tif_a.count);
        end
        rst = 1'b1;
        tif_a.command = 23'h4;
        tick();
        tick();
        n_cmp++;
        if (tif_a.count !== 3'd0 || tif_a.overflow !== 1'b0 || tif_a.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fifo: count=%0d ovf=%0b valid=%0b need 0/0/0",
                     tif_a.count, tif_a.overflow, tif_a.rd_valid);
        end
        n_cmp++;
        if (tif_a.capturing !== 1'b0 || tif_a.done !== 1'b0 || tif_b.capturing !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: cap=%0b done=%0b cap_b=%0b need 0/0/0",
                     tif_a.capturing, tif_a.done, tif_b.capturing);
        end
        do_reset();
    endtask

    task automatic test_arm_latency();
        do_reset();
        arm_pulse();
        n_cmp++;
        if (tif_a.capturing !== 1'b1 || tif_a.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL arm_state: cap=%0b valid=%0b need 1/0", tif_a.capturing, tif_a.rd_valid);
        end
        drive(23'h0, 16'h9, 1'b0);
        drive(23'h0, 16'h9, 1'b0);
        drive(23'h0, 16'h9, 1'b0);
        n_cmp++;
        if (tif_a.count !== 3'd0) begin
            n_err++;
            $display("FAIL arm_zero_cmd: count=%0d need 0", tif_a.count);
        end
        drive(23'h000001, 16'h0005, 1'b1);
        n_cmp++;
        if (tif_a.rd_valid !== 1'b1 || tif_a.count !== 3'd1 || tif_a.rd_ts !== 16'd3) begin
            n_err++;
            $display("FAIL arm_latency: valid=%0b count=%0d ts=%0d need 1/1/3",
                     tif_a.rd_valid, tif_a.count, tif_a.rd_ts);
        end
        drive(23'h000001, 16'h0006, 1'b0);
        n_cmp++;
        if (tif_a.count !== 3'd1 || tif_a.capturing !== 1'b1) begin
            n_err++;
            $display("FAIL arm_hold: count=%0d cap=%0b need 1/1", tif_a.count, tif_a.capturing);
        end
        drain_and_score(1, "arm_entry");
    endtask

    task automatic test_change_only();
        drive(23'h10, 16'h11, 1'b1);
        for (int i = 0; i < 4; i++) drive(23'h10, 16'h11 + 16'(i), 1'b0);
        drive(23'h20, 16'h22, 1'b1);
        n_cmp++;
        if (tif_a.count !== 3'd2) begin
            n_err++;
            $display("FAIL change_count: count=%0d need 2", tif_a.count);
        end
        n_cmp++;
        if (exp_q.size() != 2 || (exp_q[1].ts - exp_q[0].ts) !== 16'd5) begin
            n_err++;
            $display("FAIL change_model: queued=%0d need 2 with ts gap 5", exp_q.size());
        end
        drain_and_score(2, "change_entry");
    endtask

    task automatic test_overflow();
        do_reset();
        arm_pulse();
        for (int i = 1; i <= 6; i++) drive(23'(i), 16'(i * 3), i <= 4);
        n_cmp++;
        if (tif_a.count !== 3'd4 || tif_a.overflow !== 1'b1 || tif_a.capturing !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_run: count=%0d ovf=%0b cap=%0b need 4/1/1",
                     tif_a.count, tif_a.overflow, tif_a.capturing);
        end
        n_cmp++;
        if (tif_b.count !== 3'd4 || tif_b.overflow !== 1'b0 || tif_b.done !== 1'b1 || tif_b.capturing !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_stop_on_full: count=%0d ovf=%0b done=%0b cap=%0b need 4/0/1/0",
                     tif_b.count, tif_b.overflow, tif_b.done, tif_b.capturing);
        end
        drain_and_score(4, "ovf_entry");
        n_cmp++;
        if (tif_a.count !== 3'd0 || tif_a.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: count=%0d ovf=%0b need 0/1", tif_a.count, tif_a.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        entry_t e;
        do_reset();
        arm_pulse();
        for (int i = 1; i <= 4; i++) drive(23'(i), 16'(16'h40 + i), 1'b1);
        n_cmp++;
        if (tif_a.count !== 3'd4 || tif_a.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_fill: count=%0d ovf=%0b need 4/0", tif_a.count, tif_a.overflow);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (tif_a.rd_cmd !== e.cmd || tif_a.rd_ts !== e.ts || tif_a.rd_bus !== e.bus) begin
            n_err++;
            $display("FAIL full_head: ts=%h cmd=%h bus=%h need ts=%h cmd=%h bus=%h",
                     tif_a.rd_ts, tif_a.rd_cmd, tif_a.rd_bus, e.ts, e.cmd, e.bus);
        end
        tif_a.rd_ready = 1'b1;
        drive(23'h5, 16'h55, 1'b1);
        tif_a.rd_ready = 1'b0;
        n_cmp++;
        if (tif_a.count !== 3'd4 || tif_a.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%0b need 4/0", tif_a.count, tif_a.overflow);
        end
        drain_and_score(4, "full_entry");
    endtask

    task automatic test_stop_rearm();
        do_reset();
        arm_pulse();
        drive(23'h7, 16'h70, 1'b1);
        tif_a.stop = 1'b1;
        drive(23'h8, 16'h80, 1'b1);
        tif_a.stop = 1'b0;
        armed_m = 1'b0;
        n_cmp++;
        if (tif_a.done !== 1'b1 || tif_a.capturing !== 1'b0 || tif_a.count !== 3'd2) begin
            n_err++;
            $display("FAIL stop_state: done=%0b cap=%0b count=%0d need 1/0/2",
                     tif_a.done, tif_a.capturing, tif_a.count);
        end
        drive(23'h9, 16'h90, 1'b0);
        n_cmp++;
        if (tif_a.count !== 3'd2 || tif_a.done !== 1'b1) begin
            n_err++;
            $display("FAIL done_hold: count=%0d done=%0b need 2/1", tif_a.count, tif_a.done);
        end
        arm_pulse();
        exp_q.delete();
        n_cmp++;
        if (tif_a.count !== 3'd0 || tif_a.capturing !== 1'b1 || tif_a.done !== 1'b0) begin
            n_err++;
            $display("FAIL rearm_flush: count=%0d cap=%0b done=%0b need 0/1/0",
                     tif_a.count, tif_a.capturing, tif_a.done);
        end
        drive(23'h9, 16'h91, 1'b1);
        drain_and_score(1, "rearm_entry");
        tif_a.arm = 1'b1; tif_a.stop = 1'b1;
        drive(23'h9, 16'h91, 1'b0);
        tif_a.arm = 1'b0; tif_a.stop = 1'b0;
        armed_m = 1'b0;
        n_cmp++;
        if (tif_a.done !== 1'b1 || tif_a.capturing !== 1'b0) begin
            n_err++;
            $display("FAIL arm_stop_capture: done=%0b cap=%0b need 1/0", tif_a.done, tif_a.capturing);
        end
        tif_a.stop = 1'b1;
        arm_pulse();
        tif_a.stop = 1'b0;
        n_cmp++;
        if (tif_a.done !== 1'b0 || tif_a.capturing !== 1'b1) begin
            n_err++;
            $display("FAIL arm_stop_done: done=%0b cap=%0b need 0/1", tif_a.done, tif_a.capturing);
        end
    endtask

    initial begin
        tif_a.arm = 1'b0; tif_a.stop = 1'b0; tif_a.rd_ready = 1'b0;
        tif_a.command = '0; tif_a.bus = '0;
        test_reset();
        test_arm_latency();
        test_change_only();
        test_overflow();
        test_full_push_pop();
        test_stop_rearm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
